// File: rtl/alu_arbiter_pkg.sv
// Shared CPU definitions: ALU function codes, condition-code bit positions,
// Y86 condition selectors and datapath defaults.
package cpu_defs;

  localparam int BIT_WISE_DEFAULT = 64;
  localparam int CC_W_DEFAULT     = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } aluFun_e;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
  localparam int CC_CF = 3;

  localparam logic [3:0] CC_RESET = 4'b0001;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'd0,
    C_LE     = 4'd1,
    C_L      = 4'd2,
    C_E      = 4'd3,
    C_NE     = 4'd4,
    C_GE     = 4'd5,
    C_G      = 4'd6
  } condFun_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the response
// consumer and the shared ALU arbiter.
interface alu_arbiter_if #(
  parameter int BIT_WISE = cpu_defs::BIT_WISE_DEFAULT,
  parameter int CC_W     = cpu_defs::CC_W_DEFAULT
);
  logic                req0_valid;
  logic                req0_ready;
  logic [1:0]          req0_fun;
  logic [BIT_WISE-1:0] req0_a;
  logic [BIT_WISE-1:0] req0_b;
  logic                req0_set_cc;

  logic                req1_valid;
  logic                req1_ready;
  logic [1:0]          req1_fun;
  logic [BIT_WISE-1:0] req1_a;
  logic [BIT_WISE-1:0] req1_b;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [BIT_WISE-1:0] rsp_valE;
  logic [CC_W-1:0]     rsp_flags;

  logic [CC_W-1:0]     cc;
  logic [3:0]          cond_fun;
  logic                cond;

  modport slave (
    input  req0_valid, req0_fun, req0_a, req0_b, req0_set_cc,
    input  req1_valid, req1_fun, req1_a, req1_b,
    input  rsp_ready, cond_fun,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_valE, rsp_flags, cc, cond
  );

  modport master (
    output req0_valid, req0_fun, req0_a, req0_b, req0_set_cc,
    output req1_valid, req1_fun, req1_a, req1_b,
    output rsp_ready, cond_fun,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_valE, rsp_flags, cc, cond
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational team ALU: add, sub (B minus A), and, or, with ZF/SF/OF/CF
// flags where OF and CF are correct for both add and sub.
module alu_arbiter_alu
  import cpu_defs::*;
#(
  parameter int BIT_WISE = BIT_WISE_DEFAULT,
  parameter int CC_W     = CC_W_DEFAULT
) (
  input  logic [1:0]          i_fun,
  input  logic [BIT_WISE-1:0] i_a,
  input  logic [BIT_WISE-1:0] i_b,
  output logic [BIT_WISE-1:0] o_valE,
  output logic [CC_W-1:0]     o_flags
);
  localparam int MSB = BIT_WISE - 1;

  logic [BIT_WISE:0] w_sum;
  logic [BIT_WISE:0] w_diff;
  logic              w_of;
  logic              w_cf;

  // The extra top bit of each result is the carry (add) or borrow (sub).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_b} - {1'b0, i_a};

  always_comb begin
    o_valE = '0;
    w_of   = 1'b0;
    w_cf   = 1'b0;
    case (i_fun)
      ALU_ADD: begin
        o_valE = w_sum[MSB:0];
        w_cf   = w_sum[BIT_WISE];
        w_of   = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        o_valE = w_diff[MSB:0];
        w_cf   = w_diff[BIT_WISE];
        w_of   = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_b[MSB]);
      end
      ALU_AND: o_valE = i_a & i_b;
      ALU_OR:  o_valE = i_a | i_b;
      default: o_valE = '0;
    endcase
  end

  always_comb begin
    o_flags        = '0;
    o_flags[CC_ZF] = (o_valE == '0);
    o_flags[CC_SF] = o_valE[MSB];
    o_flags[CC_OF] = w_of;
    o_flags[CC_CF] = w_cf;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of the execute-stage ALU between two requesters, with a
// two-stage op/response pipeline, the architectural CC register and Y86 cond.
module alu_arbiter
  import cpu_defs::*;
#(
  parameter int BIT_WISE = BIT_WISE_DEFAULT,
  parameter int CC_W     = CC_W_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  logic                r_rrLast;
  logic                r_aValid;
  logic                r_aId;
  logic [1:0]          r_aFun;
  logic [BIT_WISE-1:0] r_aA;
  logic [BIT_WISE-1:0] r_aB;
  logic                r_aSetCc;
  logic                r_rspValid;
  logic                r_rspId;
  logic [BIT_WISE-1:0] r_rspValE;
  logic [CC_W-1:0]     r_rspFlags;
  logic [CC_W-1:0]     r_cc;

  logic                w_stall;
  logic                w_pick1;
  logic                w_grant0;
  logic                w_grant1;
  logic [BIT_WISE-1:0] w_valE;
  logic [CC_W-1:0]     w_flags;
  logic                w_lt;

  // A held response freezes the whole pipe, so nothing may be granted.
  assign w_stall  = r_rspValid && !bus.rsp_ready;
  assign w_pick1  = bus.req1_valid && (!bus.req0_valid || !r_rrLast);
  assign w_grant0 = !w_stall && bus.req0_valid && !w_pick1;
  assign w_grant1 = !w_stall && w_pick1;

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrLast <= 1'b1;
    end else if (w_grant0 || w_grant1) begin
      r_rrLast <= w_grant1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aValid <= 1'b0;
      r_aId    <= 1'b0;
      r_aFun   <= ALU_ADD;
      r_aA     <= '0;
      r_aB     <= '0;
      r_aSetCc <= 1'b0;
    end else if (!w_stall) begin
      r_aValid <= w_grant0 || w_grant1;
      if (w_grant0 || w_grant1) begin
        r_aId    <= w_grant1;
        r_aFun   <= w_grant1 ? bus.req1_fun : bus.req0_fun;
        r_aA     <= w_grant1 ? bus.req1_a : bus.req0_a;
        r_aB     <= w_grant1 ? bus.req1_b : bus.req0_b;
        r_aSetCc <= w_grant0 && bus.req0_set_cc;
      end
    end
  end

  alu_arbiter_alu #(
    .BIT_WISE(BIT_WISE),
    .CC_W    (CC_W)
  ) u_alu (
    .i_fun  (r_aFun),
    .i_a    (r_aA),
    .i_b    (r_aB),
    .o_valE (w_valE),
    .o_flags(w_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspValid <= 1'b0;
      r_rspId    <= 1'b0;
      r_rspValE  <= '0;
      r_rspFlags <= '0;
    end else if (!w_stall) begin
      r_rspValid <= r_aValid;
      if (r_aValid) begin
        r_rspId    <= r_aId;
        r_rspValE  <= w_valE;
        r_rspFlags <= w_flags;
      end
    end
  end

  // CC commits alongside the response load, and only for port 0 ops that ask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc <= CC_W'(CC_RESET);
    end else if (!w_stall && r_aValid && !r_aId && r_aSetCc) begin
      r_cc <= w_flags;
    end
  end

  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_id    = r_rspId;
  assign bus.rsp_valE  = r_rspValE;
  assign bus.rsp_flags = r_rspFlags;
  assign bus.cc        = r_cc;

  assign w_lt = r_cc[CC_SF] ^ r_cc[CC_OF];

  always_comb begin
    bus.cond = 1'b0;
    case (bus.cond_fun)
      C_ALWAYS: bus.cond = 1'b1;
      C_LE:     bus.cond = w_lt || r_cc[CC_ZF];
      C_L:      bus.cond = w_lt;
      C_E:      bus.cond = r_cc[CC_ZF];
      C_NE:     bus.cond = !r_cc[CC_ZF];
      C_GE:     bus.cond = !w_lt;
      C_G:      bus.cond = !w_lt && !r_cc[CC_ZF];
      default:  bus.cond = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, handshake/backpressure/reset
// sequences, and a randomized run against a scoreboard reference model.
module tb_alu_arbiter;
  import cpu_defs::*;

  localparam int BW = 64;

  typedef struct packed {
    logic [63:0] valE;
    logic [3:0]  flags;
  } aluRes_t;

  typedef struct {
    logic        id;
    logic        setCc;
    logic [63:0] valE;
    logic [3:0]  flags;
  } expRsp_t;

  typedef struct {
    logic        port;
    logic [1:0]  fun;
    logic [63:0] a;
    logic [63:0] b;
    logic        setCc;
    logic [3:0]  condFun;
    logic [63:0] expValE;
    logic [3:0]  expFlags;
    logic [3:0]  expCc;
    logic        expCond;
  } vec_t;

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;

  alu_arbiter_if #(.BIT_WISE(BW), .CC_W(4)) bus ();

  alu_arbiter #(.BIT_WISE(BW), .CC_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the test finished");
    $fatal(1, "[TB] watchdog");
  end

  // Reference ALU from the arithmetic definitions: exact signed result vs
  // wrapped result gives overflow, unsigned compare/carry gives CF.
  function automatic aluRes_t refAlu(input logic [1:0] fun, input logic [63:0] a,
                                     input logic [63:0] b);
    aluRes_t            r;
    logic [64:0]        wide;
    logic signed [65:0] exact;
    r     = '0;
    wide  = '0;
    exact = '0;
    case (fun)
      2'd0: begin
        wide       = 65'(a) + 65'(b);
        r.valE     = wide[63:0];
        r.flags[3] = wide[64];
        exact      = 66'($signed(a)) + 66'($signed(b));
        r.flags[2] = (exact != 66'($signed(r.valE)));
      end
      2'd1: begin
        r.valE     = b - a;
        r.flags[3] = (b < a);
        exact      = 66'($signed(b)) - 66'($signed(a));
        r.flags[2] = (exact != 66'($signed(r.valE)));
      end
      2'd2: r.valE = a & b;
      default: r.valE = a | b;
    endcase
    r.flags[0] = (r.valE == 64'd0);
    r.flags[1] = r.valE[63];
    return r;
  endfunction

  function automatic logic refCond(input logic [3:0] ccv, input logic [3:0] fn);
    logic zf;
    logic lt;
    zf = ccv[0];
    lt = (ccv[1] != ccv[2]);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
  endtask

  task automatic idleInputs();
    bus.req0_valid  = 1'b0;
    bus.req0_fun    = 2'd0;
    bus.req0_a      = '0;
    bus.req0_b      = '0;
    bus.req0_set_cc = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.req1_fun    = 2'd0;
    bus.req1_a      = '0;
    bus.req1_b      = '0;
    bus.rsp_ready   = 1'b1;
    bus.cond_fun    = 4'd0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic driveReq0(input logic v, input logic [1:0] f, input logic [63:0] a,
                           input logic [63:0] b, input logic s);
    bus.req0_valid  = v;
    bus.req0_fun    = f;
    bus.req0_a      = a;
    bus.req0_b      = b;
    bus.req0_set_cc = s;
  endtask

  task automatic driveReq1(input logic v, input logic [1:0] f, input logic [63:0] a,
                           input logic [63:0] b);
    bus.req1_valid = v;
    bus.req1_fun   = f;
    bus.req1_a     = a;
    bus.req1_b     = b;
  endtask

  // One isolated op: accepted at once, response exactly two cycles later.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.cond_fun  = v.condFun;
    bus.rsp_ready = 1'b1;
    if (v.port) begin
      driveReq0(1'b0, 2'd0, '0, '0, 1'b0);
      driveReq1(1'b1, v.fun, v.a, v.b);
    end else begin
      driveReq1(1'b0, 2'd0, '0, '0);
      driveReq0(1'b1, v.fun, v.a, v.b, v.setCc);
    end
    #1;
    checkOutput("vecReady", v.port ? bus.req1_ready : bus.req0_ready, 64'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    checkOutput("vecEarlyRsp", bus.rsp_valid, 64'd0);
    @(negedge clk);
    #1;
    checkOutput("vecRspValid", bus.rsp_valid, 64'd1);
    checkOutput("vecRspId", bus.rsp_id, 64'(v.port));
    checkOutput("vecValE", bus.rsp_valE, v.expValE);
    checkOutput("vecFlags", bus.rsp_flags, 64'(v.expFlags));
    checkOutput("vecCc", bus.cc, 64'(v.expCc));
    checkOutput("vecCond", bus.cond, 64'(v.expCond));
  endtask

  task automatic runRandom(input int cycles);
    expRsp_t     sbQ[$];
    expRsp_t     cur;
    expRsp_t     e;
    aluRes_t     r;
    logic        haveCur = 1'b0;
    logic [3:0]  modelCc = 4'b0001;
    logic        modelRr = 1'b1;
    logic        pend[2];
    logic [1:0]  pFun[2];
    logic [63:0] pA[2];
    logic [63:0] pB[2];
    logic        pSet[2];
    logic        stall;
    logic        exp0;
    logic        exp1;
    logic        draining;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      pFun[p] = 2'd0;
      pA[p]   = '0;
      pB[p]   = '0;
      pSet[p] = 1'b0;
    end
    cur = '{1'b0, 1'b0, 64'd0, 4'd0};
    for (int c = 0; c < cycles + 20; c++) begin
      draining = (c >= cycles);
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && !draining && $urandom_range(0, 3) != 0) begin
          pend[p] = 1'b1;
          pFun[p] = 2'($urandom_range(0, 3));
          pA[p]   = randOperand();
          pB[p]   = randOperand();
          pSet[p] = (p == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
      driveReq0(pend[0], pFun[0], pA[0], pB[0], pSet[0]);
      driveReq1(pend[1], pFun[1], pA[1], pB[1]);
      bus.rsp_ready = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.cond_fun  = 4'($urandom_range(0, 15));
      #1;
      if (bus.rsp_valid) begin
        if (!haveCur) begin
          if (sbQ.size() == 0) begin
            checkOutput("randUnexpectedRsp", 64'd1, 64'd0);
          end else begin
            cur     = sbQ.pop_front();
            haveCur = 1'b1;
            if (!cur.id && cur.setCc) modelCc = cur.flags;
          end
        end
        if (haveCur) begin
          checkOutput("randRspId", bus.rsp_id, 64'(cur.id));
          checkOutput("randRspValE", bus.rsp_valE, cur.valE);
          checkOutput("randRspFlags", bus.rsp_flags, 64'(cur.flags));
        end
        if (bus.rsp_ready) haveCur = 1'b0;
      end
      checkOutput("randCc", bus.cc, 64'(modelCc));
      checkOutput("randCond", bus.cond, 64'(refCond(modelCc, bus.cond_fun)));
      stall = bus.rsp_valid && !bus.rsp_ready;
      exp0  = !stall && pend[0] && (!pend[1] || modelRr);
      exp1  = !stall && pend[1] && (!pend[0] || !modelRr);
      checkOutput("randReady", {bus.req1_ready, bus.req0_ready}, {exp1, exp0});
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && (p == 0 ? bus.req0_ready : bus.req1_ready)) begin
          r       = refAlu(pFun[p], pA[p], pB[p]);
          e.id    = 1'(p);
          e.setCc = pSet[p];
          e.valE  = r.valE;
          e.flags = r.flags;
          sbQ.push_back(e);
          pend[p] = 1'b0;
          modelRr = 1'(p);
        end
      end
    end
    checkOutput("randDrained", 64'(sbQ.size()) + 64'(haveCur) + 64'(pend[0]) + 64'(pend[1]),
                64'd0);
  endtask

  initial begin
    vec_t vecs[9];
    vecs[0] = '{1'b0, 2'd1, 64'd5, 64'd3, 1'b1, 4'd2,
                64'hFFFF_FFFF_FFFF_FFFE, 4'b1010, 4'b1010, 1'b1};
    vecs[1] = '{1'b0, 2'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd6,
                64'd0, 4'b1001, 4'b1010, 1'b0};
    vecs[2] = '{1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd5,
                64'h8000_0000_0000_0000, 4'b0110, 4'b1010, 1'b0};
    vecs[3] = '{1'b0, 2'd2, 64'hF0, 64'h0F, 1'b1, 4'd3,
                64'd0, 4'b0001, 4'b0001, 1'b1};
    vecs[4] = '{1'b0, 2'd3, 64'd0, 64'h8000_0000_0000_0000, 1'b1, 4'd1,
                64'h8000_0000_0000_0000, 4'b0010, 4'b0010, 1'b1};
    vecs[5] = '{1'b0, 2'd1, 64'd5, 64'd5, 1'b1, 4'd4,
                64'd0, 4'b0001, 4'b0001, 1'b0};
    vecs[6] = '{1'b0, 2'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 4'd2,
                64'h7FFF_FFFF_FFFF_FFFF, 4'b0100, 4'b0100, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd9,
                64'hFFFF_FFFF_FFFF_FFFE, 4'b1010, 4'b1010, 1'b0};
    vecs[8] = '{1'b1, 2'd1, 64'd3, 64'd10, 1'b0, 4'd0,
                64'd7, 4'b0000, 4'b1010, 1'b1};

    rst = 1'b1;
    idleInputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.cond_fun = 4'd3;
    #1;
    checkOutput("resetCc", bus.cc, 64'h1);
    checkOutput("resetRspValid", bus.rsp_valid, 64'd0);
    checkOutput("resetRspId", bus.rsp_id, 64'd0);
    checkOutput("resetValE", bus.rsp_valE, 64'd0);
    checkOutput("resetFlags", bus.rsp_flags, 64'd0);
    checkOutput("resetCondE", bus.cond, 64'd1);
    bus.cond_fun = 4'd4;
    #1;
    checkOutput("resetCondNe", bus.cond, 64'd0);

    // Both ports valid for four grants: strict alternation starting at port 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      driveReq0(i < 4, 2'd0, 64'd2, 64'd3, 1'b0);
      driveReq1(i < 4, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      bus.rsp_ready = 1'b1;
      #1;
      if (i < 4) begin
        checkOutput("altReady0", bus.req0_ready, 64'(i % 2 == 0));
        checkOutput("altReady1", bus.req1_ready, 64'(i % 2 == 1));
      end
      if (i >= 2) begin
        checkOutput("altRspValid", bus.rsp_valid, 64'd1);
        checkOutput("altRspId", bus.rsp_id, 64'((i - 2) % 2));
        checkOutput("altValE", bus.rsp_valE,
                    ((i - 2) % 2 == 1) ? 64'h8000_0000_0000_0000 : 64'd5);
        checkOutput("altFlags", bus.rsp_flags, ((i - 2) % 2 == 1) ? 64'b0110 : 64'b0000);
      end
    end
    checkOutput("altCcUnchanged", bus.cc, 64'h1);

    // Two accepts, then a three-cycle stalled response with both ports waiting.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      driveReq0(i < 5, 2'd1, 64'd2, 64'd10, 1'b1);
      driveReq1(i < 5, 2'd3, 64'hF0, 64'h0F);
      bus.rsp_ready = (i >= 5);
      #1;
      if (i == 0) checkOutput("bpGrant0", {bus.req1_ready, bus.req0_ready}, 64'b01);
      if (i == 1) checkOutput("bpGrant1", {bus.req1_ready, bus.req0_ready}, 64'b10);
      if (i >= 2 && i <= 4) begin
        checkOutput("bpBlocked", {bus.req1_ready, bus.req0_ready}, 64'b00);
        checkOutput("bpHeldValid", bus.rsp_valid, 64'd1);
        checkOutput("bpHeldId", bus.rsp_id, 64'd0);
        checkOutput("bpHeldValE", bus.rsp_valE, 64'd8);
        checkOutput("bpCc", bus.cc, 64'h0);
      end
      if (i == 5) begin
        checkOutput("bpDrain0Id", bus.rsp_id, 64'd0);
        checkOutput("bpDrain0ValE", bus.rsp_valE, 64'd8);
      end
      if (i == 6) begin
        checkOutput("bpDrain1Valid", bus.rsp_valid, 64'd1);
        checkOutput("bpDrain1Id", bus.rsp_id, 64'd1);
        checkOutput("bpDrain1ValE", bus.rsp_valE, 64'hFF);
        checkOutput("bpDrain1Flags", bus.rsp_flags, 64'd0);
      end
      if (i == 7) checkOutput("bpNoDuplicate", bus.rsp_valid, 64'd0);
    end

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    doReset();
    runRandom(500);

    // Reset with one op in each stage: everything in flight disappears.
    doReset();
    @(negedge clk);
    driveReq0(1'b1, 2'd1, 64'd5, 64'd3, 1'b1);
    driveReq1(1'b1, 2'd0, 64'd1, 64'd1);
    #1;
    checkOutput("rstMidGrant0", bus.req0_ready, 64'd1);
    @(negedge clk);
    #1;
    checkOutput("rstMidGrant1", bus.req1_ready, 64'd1);
    @(negedge clk);
    driveReq0(1'b0, 2'd0, '0, '0, 1'b0);
    driveReq1(1'b0, 2'd0, '0, '0);
    #1;
    checkOutput("rstMidRspBefore", bus.rsp_valid, 64'd1);
    checkOutput("rstMidCcBefore", bus.cc, 64'b1010);
    rst = 1'b1;
    #1;
    checkOutput("rstMidRspDrop", bus.rsp_valid, 64'd0);
    checkOutput("rstMidCcReset", bus.cc, 64'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rstMidNoRsp", bus.rsp_valid, 64'd0);
    end
    checkOutput("rstMidCcAfter", bus.cc, 64'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
